ahbl_apb_bridge: RTL and testbench
==================================

Name: ahbl_apb_bridge

Overview:
AHB-Lite slave that consumes transfers from the AHB-Lite master bus-functional model and converts them to APB3 transfers. It drives the APB peripherals, such as the UART.
- Handles one transfer at a time, with a one-hot PSEL decode across up to 16 APB slots.
- Includes an optional PREADY timeout.
- Sits between the AHB-Lite master side (HADDR/HTRANS/HWDATA) and the APB slave side.

Parameters:
PADDR_WIDTH, 12, width of PADDR; slot index is HADDR[PADDR_WIDTH+3:PADDR_WIDTH].
NUM_SLOTS, 16, number of PSEL outputs (1..16); slot index >= NUM_SLOTS gives an error response.
TIMEOUT, 255, maximum ACCESS cycles waiting on PREADY (1..65535); 0 disables the timeout.

Ports:
HCLK  in  1  single clock; rising edge.
HRESETN  in  1  asynchronous active-low reset.
HSEL  in  1  bridge selected.
HADDR  in  32  AHB address.
HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
HWRITE  in  1  AHB direction.
HSIZE  in  3  accepted; not used.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-wide ready; qualifies the address phase.
HREADYOUT  out  1  bridge ready, registered.
HRESP  out  1  0=OKAY, 1=ERROR, registered.
HRDATA  out  32  read data, registered.
PSEL  out  NUM_SLOTS  one-hot APB select.
PENABLE  out  1  APB access phase.
PWRITE  out  1  APB direction.
PADDR  out  PADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PRDATA  in  32  APB read data, muxed externally.
PREADY  in  1  APB ready, muxed externally.
PSLVERR  in  1  APB error, muxed externally.

Behaviour:
- Reset values, asynchronous on HRESETN=0:
  - state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter=0.
- Address accept condition: HSEL & HREADY & HTRANS[1] in IDLE or ERR2.
  - On accept, latch HADDR, HWRITE and slot index.
  - Set HREADYOUT=0, HRESP=0, go to WDATA.
- HSEL=0 or HTRANS=IDLE/BUSY while in IDLE: no action; HREADYOUT stays 1 (zero-wait OKAY).
- WDATA, one cycle (AHB data phase):
  - If write, latch HWDATA into PWDATA.
  - If slot index >= NUM_SLOTS, go to ERR1 without any APB activity.
  - Otherwise go to SETUP.
- SETUP:
  - PSEL[slot]=1, PENABLE=0; PADDR = latched HADDR[PADDR_WIDTH-1:0]; PWRITE = latched HWRITE.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1, and PSEL, PADDR, PWRITE, PWDATA are held stable.
  - The counter increments each cycle that PREADY=0.
  - PREADY=1 & PSLVERR=0: if read, HRDATA<=PRDATA; drop PSEL and PENABLE; HREADYOUT<=1; go to IDLE.
  - PREADY=1 & PSLVERR=1: drop PSEL and PENABLE; go to ERR1. HRDATA is not updated.
  - TIMEOUT!=0 and counter reaches TIMEOUT with PREADY=0: drop PSEL and PENABLE; go to ERR1.
- ERR1: HRESP=1, HREADYOUT=0; next state ERR2.
- ERR2: HRESP=1, HREADYOUT=1; accepts a new address phase as IDLE does, otherwise goes to IDLE with HRESP<=0.
- Minimum data phase: 3 wait states (WDATA, SETUP, ACCESS) and then HREADYOUT=1.
- The counter clears on entry to SETUP. It is 16 bits wide and saturates; it never wraps.
- An asynchronous reset mid-transfer drops PSEL and PENABLE immediately. No completion is reported.
- A master that cancels after ERR1 by driving HTRANS=IDLE is legal; the bridge goes to IDLE after ERR2.
- PWDATA and HRDATA hold their last values when not updated.

Decomposition:
- Package ahbl_apb_pkg holds:
  - the state enum IDLE/WDATA/SETUP/ACCESS/ERR1/ERR2;
  - HTRANS codes (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - HRESP codes OKAY/ERROR.
- No sub-module is needed. The timeout counter and the PSEL decoder are inline.

Test Plan:
- Write: HADDR=0x0000_1010 (slot 1), HWDATA=0xDEAD_BEEF, PREADY=1 -> PSEL=0x0002 and PADDR=0x010 with PWDATA=0xDEAD_BEEF through SETUP/ACCESS; HREADYOUT low 3 cycles; HRESP=0.
- Read: slot 0 addr 0x004, PRDATA=0x1234_5678, PREADY low 4 ACCESS cycles -> HRDATA=0x1234_5678 when HREADYOUT rises; 7 total wait states.
- PSLVERR=1 on a read -> two-cycle error response: HRESP=1 with HREADYOUT 0 then 1; HRDATA unchanged.
- TIMEOUT=8, PREADY held 0 -> PENABLE drops after 8 ACCESS cycles, then the two-cycle error response.
- NUM_SLOTS=4, HADDR slot 5 -> no PSEL asserted; two-cycle error response.
- Back-to-back writes with the second address phase during ERR2, plus HRESETN pulsed during ACCESS -> second transfer accepted; reset clears PSEL/PENABLE at once and sets HREADYOUT=1.

Source files
------------

// File: rtl/ahbl_apb_pkg.sv
// Shared types for the AHB-Lite to APB3 bridge: FSM states and AHB bus encodings.
package ahbl_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that converts one transfer at a time into an APB3 transfer,
// with one-hot PSEL decode, out-of-range slot errors and an optional PREADY timeout.
module ahbl_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int PADDR_WIDTH = 12,
    parameter int NUM_SLOTS   = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESETN,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [31:0]            HRDATA,
    output logic [NUM_SLOTS-1:0]   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic [31:0]            PWDATA,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam logic [4:0]           NUM_SLOTS_W = 5'(NUM_SLOTS);
    localparam logic [16:0]          TIMEOUT_W   = 17'(TIMEOUT);
    localparam logic [NUM_SLOTS-1:0] PSEL_ONE    = NUM_SLOTS'(1);

    state_e                 state;
    logic [PADDR_WIDTH-1:0] addr_q;
    logic [3:0]             slot_q;
    logic                   write_q;
    logic [15:0]            wait_cnt;

    logic accept;
    logic slot_bad;
    logic timed_out;
    logic unused_ok;

    assign accept    = HSEL && HREADY &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign slot_bad  = ({1'b0, slot_q} >= NUM_SLOTS_W);
    // This cycle would be the TIMEOUT-th ACCESS cycle spent waiting on PREADY.
    assign timed_out = (TIMEOUT != 0) && (({1'b0, wait_cnt} + 17'd1) >= TIMEOUT_W);

    assign unused_ok = ^{HSIZE, HADDR[31:PADDR_WIDTH+4]};

    // NOTE: every output is a register written only here with non-blocking
    // assignments, so each branch sees pre-edge values and no output glitches.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            addr_q    <= '0;
            slot_q    <= '0;
            write_q   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    HRESP <= HRESP_OKAY;
                    if (accept) begin
                        addr_q    <= HADDR[PADDR_WIDTH-1:0];
                        slot_q    <= HADDR[PADDR_WIDTH+3 -: 4];
                        write_q   <= HWRITE;
                        HREADYOUT <= 1'b0;
                        state     <= ST_WDATA;
                    end else begin
                        HREADYOUT <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                ST_WDATA: begin
                    if (write_q) begin
                        PWDATA <= HWDATA;
                    end
                    if (slot_bad) begin
                        HRESP <= HRESP_ERROR;
                        state <= ST_ERR1;
                    end else begin
                        PSEL     <= PSEL_ONE << slot_q;
                        PENABLE  <= 1'b0;
                        PADDR    <= addr_q;
                        PWRITE   <= write_q;
                        wait_cnt <= '0;
                        state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            HRESP <= HRESP_ERROR;
                            state <= ST_ERR1;
                        end else begin
                            if (!write_q) begin
                                HRDATA <= PRDATA;
                            end
                            HREADYOUT <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                        if (timed_out) begin
                            PSEL    <= '0;
                            PENABLE <= 1'b0;
                            HRESP   <= HRESP_ERROR;
                            state   <= ST_ERR1;
                        end
                    end
                end

                // First error cycle stalls; second cycle completes with ERROR.
                ST_ERR1: begin
                    HREADYOUT <= 1'b1;
                    state     <= ST_ERR2;
                end

                default: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Randomized self-checking bench: AHB master driver, parameterised APB slave,
// and a transaction-level model of wait states, responses and data.
module tb_ahbl_apb_bridge;
    import ahbl_apb_pkg::*;

    localparam int PAW     = 12;
    localparam int NSLOTS  = 4;
    localparam int TMO     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              hready;
    logic              hready_en;
    logic              hreadyout;
    logic              hresp;
    logic [31:0]       hrdata;
    logic [NSLOTS-1:0] psel;
    logic              penable;
    logic              pwrite;
    logic [PAW-1:0]    paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    int          checks   = 0;
    int          failures = 0;
    int          cfg_waits = 0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt   = 0;
    logic [31:0] exp_pwdata = '0;
    logic [31:0] exp_hrdata = '0;

    always #5 clk = ~clk;

    ahbl_apb_bridge #(
        .PADDR_WIDTH (PAW),
        .NUM_SLOTS   (NSLOTS),
        .TIMEOUT     (TMO)
    ) dut (
        .HCLK      (clk),
        .HRESETN   (rst_n),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    // Single slave on the bus, so the bus-wide HREADY is the bridge's own.
    assign hready  = hreadyout & hready_en;

    // APB slave: holds PREADY low for cfg_waits ACCESS cycles.
    assign pready  = penable && (acc_cnt >= cfg_waits);
    assign pslverr = pready && cfg_err;
    assign prdata  = cfg_rdata;

    always @(posedge clk) begin
        if (penable && !pready) acc_cnt <= acc_cnt + 1;
        else if (!penable)      acc_cnt <= 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One AHB transfer preceded by `gap` non-accepted cycles, checked against the model.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic serr, input logic [31:0] rdata,
                        input int gap);
        int          slot;
        logic        bad;
        logic        err;
        int          exp_low;
        int          exp_acc;
        logic [31:0] exp_psel;
        int          low;
        int          acc;
        int          apb_bad;
        logic [31:0] psel_seen;
        logic        last_resp;
        logic        done;

        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            hsel   = 1'b1;
            haddr  = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                htrans    = HTRANS_BUSY;
                hready_en = 1'b1;
            end else begin
                htrans    = HTRANS_NONSEQ;
                hready_en = 1'b0;
            end
            @(posedge clk); #1;
            check("idle_hreadyout", 32'(hreadyout), 32'd1);
            check("idle_hresp", 32'(hresp), 32'd0);
            check("idle_psel", 32'(psel), 32'd0);
        end

        slot = int'(addr[PAW+3:PAW]);
        bad  = (slot >= NSLOTS);
        if (bad) begin
            exp_acc  = 0;
            exp_low  = 2;
            err      = 1'b1;
            exp_psel = '0;
        end else if (TMO != 0 && waits >= TMO) begin
            exp_acc  = TMO;
            exp_low  = 3 + TMO;
            err      = 1'b1;
            exp_psel = 32'd1 << slot;
        end else begin
            exp_acc  = waits + 1;
            exp_low  = waits + 3 + (serr ? 1 : 0);
            err      = serr;
            exp_psel = 32'd1 << slot;
        end
        if (wr) exp_pwdata = wdata;

        @(negedge clk);
        hready_en = 1'b1;
        hsel      = 1'b1;
        htrans    = HTRANS_NONSEQ;
        haddr     = addr;
        hwrite    = wr;
        cfg_waits = waits;
        cfg_err   = serr;
        cfg_rdata = rdata;
        @(posedge clk); #1;

        low = 0; acc = 0; apb_bad = 0; psel_seen = '0; last_resp = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (hreadyout) begin
                done = 1'b1;
            end else begin
                low++;
                last_resp = hresp;
                if (penable) acc++;
                psel_seen = psel_seen | 32'(psel);
                if (psel != '0) begin
                    if (32'(psel) != exp_psel)   apb_bad++;
                    if (paddr != addr[PAW-1:0]) apb_bad++;
                    if (pwrite != wr)           apb_bad++;
                    if (pwdata != exp_pwdata)   apb_bad++;
                end
                @(negedge clk);
                if (c == 0) begin
                    hsel   = 1'b0;
                    htrans = HTRANS_IDLE;
                    haddr  = $urandom();
                    hwdata = wr ? wdata : $urandom();
                end
                @(posedge clk); #1;
            end
        end

        if (!wr && !err) exp_hrdata = rdata;

        check("xfer_done", 32'(done), 32'd1);
        check("wait_states", 32'(low), 32'(exp_low));
        check("access_cycles", 32'(acc), 32'(exp_acc));
        check("psel_seen", psel_seen, exp_psel);
        check("apb_stable", 32'(apb_bad), 32'd0);
        check("hresp_last_wait", 32'(last_resp), 32'(err));
        check("hresp_done", 32'(hresp), 32'(err));
        check("hrdata", hrdata, exp_hrdata);
        check("pwdata", pwdata, exp_pwdata);
    endtask

    initial begin
        logic [31:0] a;
        logic        found;
        int          w;

        rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; hready_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xfer(32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 0);
        xfer(32'h0000_0004, 1'b0, 32'h0, 4, 1'b0, 32'h1234_5678, 1);
        xfer(32'h0000_3020, 1'b0, 32'h0, 2, 1'b1, 32'hAAAA_5555, 0);
        xfer(32'h0000_2040, 1'b0, 32'h0, 12, 1'b0, 32'h7777_7777, 2);
        xfer(32'h0000_5008, 1'b1, 32'h0BAD_0001, 0, 1'b0, 32'h0, 0);
        xfer(32'h0000_2100, 1'b1, 32'h1111_2222, 1, 1'b0, 32'h0, 0);
        xfer(32'h0000_F000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0);
        xfer(32'h0000_0ABC, 1'b0, 32'h0, 7, 1'b0, 32'hFEED_FACE, 0);
        xfer(32'h0000_1FFC, 1'b1, 32'h3333_4444, 8, 1'b0, 32'h0, 0);

        // Reset while the APB access is in progress.
        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_2ABC; hwrite = 1'b1;
        cfg_waits = 100; cfg_err = 1'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFE_F00D;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk); #1;
            if (penable) found = 1'b1;
        end
        check("reach_access", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_psel", 32'(psel), 32'd0);
        check("midrst_penable", 32'(penable), 32'd0);
        check("midrst_hreadyout", 32'(hreadyout), 32'd1);
        check("midrst_hresp", 32'(hresp), 32'd0);
        exp_pwdata = '0;
        exp_hrdata = '0;
        @(negedge clk);
        rst_n = 1'b1;

        xfer(32'h0000_3300, 1'b1, 32'h5A5A_A5A5, 0, 1'b0, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            a[15:12] = 4'($urandom_range(0, 5));
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 5);
            xfer(a, 1'($urandom_range(0, 1)), $urandom(), w,
                 ($urandom_range(0, 4) == 0), $urandom(), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
